irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Prioritized interrupt controller sitting in front of `pc_ctrl`. It latches edge-triggered interrupt requests and arbitrates among the enabled pending requests. At a safe instruction boundary it injects a call to the winner's vector address through `pc_ctrl`'s goto/call inputs. Further interrupts are then blocked until the handler executes its return-from-interrupt.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of request lines (2..8).
- `VECTOR_BASE`, 12'h004: vector address of line 0.
- `VECTOR_STRIDE`, 4: address spacing between consecutive vectors.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `pause` in 1: pipeline stall; freezes the FSM, but edge capture continues.
- `irq` in NUM_IRQ: raw request lines; a rising edge sets pending.
- `mask_wr` in 1: write strobe for the enable mask.
- `mask_data` in NUM_IRQ: new enable mask; 1 = enabled.
- `gie_wr` in 1: write strobe for the global enable.
- `gie_data` in 1: new global enable value.
- `safe` in 1: boundary flag from decode; no skip/goto/call/ret is in flight and kill is low.
- `retfie` in 1: return-from-interrupt instruction is retiring this cycle.
- `int_goto` out 1: drives pc_ctrl goto (ORed upstream with the decoder's goto).
- `int_call` out 1: drives pc_ctrl call; always equal to `int_goto`.
- `int_addr` out 12: vector address; valid while `int_goto` is high.
- `in_service` out 1: a handler is running.
- `active_id` out clog2(NUM_IRQ): index of the line being serviced.
- `pending` out NUM_IRQ: pending register, readable by software.

## Operation
- Edge detect:
  - `irq_d` is a registered copy of `irq`.
  - `pending[i]` sets on `irq[i] & ~irq_d[i]`.
  - `pending[i]` clears only on acceptance of line i.
  - If set and clear coincide, set wins and the bit stays 1.
- Eligible vector = `pending & mask & {NUM_IRQ{gie}}`. The lowest index has the highest priority.
- FSM states:
  - IDLE: if eligible is nonzero, latch the winner into `active_id` and go to REQ.
  - REQ: `int_goto = int_call = safe & ~pause`. On a cycle where this is high, clear `pending[active_id]` and go to SERVICE. The winner is frozen in REQ; a higher-priority arrival waits for the next entry.
  - SERVICE: `in_service = 1`. On `retfie & ~pause`, go to IDLE.
- `retfie` in IDLE or REQ is ignored.
- `int_addr = VECTOR_BASE + active_id*VECTOR_STRIDE`, truncated to 12 bits; wrap-around is permitted.
- Mask and gie changes:
  - Writes take effect on the next cycle.
  - Clearing gie or the mask bit while in REQ does not cancel the request. Once in REQ, the call is committed.
- Nesting is not supported; arrivals during SERVICE only set pending.
- Stack overflow on the injected call is detected by pc_ctrl; this block takes no action.
- Reset, including mid-handler:
  - pending = 0, irq_d = 0, mask = 0, gie = 0, state = IDLE.
  - All outputs are 0.
  - A line held high through reset does not fire until it produces a new rising edge.

## Timing
- Rising edge of `irq` sampled at edge n: `pending` is visible after edge n+1.
- Eligible at cycle n+1: state = REQ from n+2. `int_goto` asserts combinationally in that cycle if `safe & ~pause`.
- Minimum latency from the sampled irq edge to pc_ctrl loading the vector: 3 clocks.
- `int_goto` and `int_call` are single-cycle pulses, high for exactly one unpaused cycle per acceptance.
- `in_service` rises on the edge after acceptance. It falls on the edge after an unpaused `retfie`.
- Back-to-back interrupts: the earliest next REQ is one cycle after returning to IDLE.
- `pause` holds state, `active_id`, and the outputs' registered sources. `int_goto` is forced low while `pause` is high.

## Structure
- A shared package `ez8_pkg` holds:
  - state enum values IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
  - the `PC_W = 12` constant.
- One sub-module, `prio_enc`:
  - parameterized by NUM_IRQ;
  - purely combinational lowest-index encoder;
  - outputs `any` and `idx`.
- Everything else is flat in `irq_ctrl`.

## Test plan
- Basic acceptance:
  - Stimulus: gie = 1, mask = 4'b1111, safe = 1, rising edge on irq[2].
  - Required: `int_goto` for one cycle with `int_addr` = 12'h00C, `pending[2]` clears, `in_service` rises the next cycle, and `retfie` returns to IDLE.
- Priority:
  - Stimulus: irq[3] and irq[1] rise on the same edge.
  - Required: line 1 is serviced first (addr 12'h008); line 3 is serviced after `retfie` (addr 12'h010).
- Gating by mask, safe, and pause:
  - Stimulus: mask[0] = 0 with an irq[0] edge.
  - Required: pending = 4'b0001 and no request.
  - Stimulus: set mask[0] while safe = 0 for 5 cycles, then pause = 1 for 2 cycles.
  - Required: `int_goto` stays low until safe = 1 and pause = 0, then pulses exactly once.
- Set/clear collision:
  - Stimulus: a new irq[2] edge in the same cycle as acceptance of line 2.
  - Required: `pending[2]` remains 1, and line 2 is re-serviced after `retfie`.
- Reset mid-handler:
  - Stimulus: assert reset during SERVICE while irq[0] is held high.
  - Required: all outputs are 0 and gie = 0. After re-enable, no interrupt occurs until irq[0] falls and rises again.

Source files
------------

// File: rtl/ez8_pkg.sv
// rtl/ez8_pkg.sv - shared constants and state encoding for the ez8 core blocks
package ez8_pkg;

    localparam int PC_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - combinational lowest-index-wins priority encoder
// Ports:
//   req  : request vector, bit 0 has the highest priority
//   any  : at least one request bit is set
//   idx  : index of the lowest set bit (0 when any is low)
module prio_enc #(
    parameter  int NUM_IRQ = 4,
    localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan from the top down so the lowest set bit is written last.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritized edge-triggered interrupt controller feeding pc_ctrl
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pause               : pipeline stall; freezes the FSM, edge capture continues
//   irq                 : raw request lines, rising edge sets pending
//   mask_wr, mask_data  : enable mask write (1 = enabled)
//   gie_wr, gie_data    : global interrupt enable write
//   safe                : decode reports an instruction boundary with nothing in flight
//   retfie              : return-from-interrupt retiring this cycle
//   int_goto, int_call  : injected call strobe towards pc_ctrl
//   int_addr            : vector address, zero unless int_goto is high
//   in_service          : a handler is running
//   active_id           : line currently requested or serviced
//   pending             : latched requests, software visible
module irq_ctrl
    import ez8_pkg::*;
#(
    parameter  int              NUM_IRQ       = 4,
    parameter  logic [PC_W-1:0] VECTOR_BASE   = 12'h004,
    parameter  int              VECTOR_STRIDE = 4,
    localparam int              ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pause,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               gie_wr,
    input  logic               gie_data,
    input  logic               safe,
    input  logic               retfie,
    output logic               int_goto,
    output logic               int_call,
    output logic [PC_W-1:0]    int_addr,
    output logic               in_service,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_IRQ-1:0] pending
);

    irq_state_t         state;
    irq_state_t         state_n;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] mask;
    logic               gie;
    logic               edge_armed;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic               enc_any;
    logic [ID_W-1:0]    enc_idx;
    logic               load_id;
    logic               accept;
    logic [PC_W-1:0]    vec_addr;

    // irq_d is cleared by reset, so a line held high through reset would look
    // like a fresh edge on the first cycle out of reset. edge_armed masks that
    // one cycle while irq_d catches up with the real line levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d      <= '0;
            edge_armed <= 1'b0;
        end else begin
            irq_d      <= irq;
            edge_armed <= 1'b1;
        end
    end

    assign rise = irq & ~irq_d & {NUM_IRQ{edge_armed}};

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            gie  <= 1'b0;
        end else begin
            if (mask_wr) begin
                mask <= mask_data;
            end
            if (gie_wr) begin
                gie <= gie_data;
            end
        end
    end

    assign clr_vec = accept ? (NUM_IRQ'(1) << active_id) : '0;

    // Set is applied after clear so a new edge on the accepted line survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | rise;
        end
    end

    assign eligible = pending & mask & {NUM_IRQ{gie}};

    prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req (eligible),
        .any (enc_any),
        .idx (enc_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            active_id <= '0;
        end else if (!pause) begin
            state <= state_n;
            if (load_id) begin
                active_id <= enc_idx;
            end
        end
    end

    // Once in REQ the call is committed: mask/gie changes no longer matter.
    always_comb begin
        state_n  = state;
        load_id  = 1'b0;
        accept   = 1'b0;
        int_goto = 1'b0;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_n = REQ;
                    load_id = 1'b1;
                end
            end
            REQ: begin
                int_goto = safe & ~pause;
                if (int_goto) begin
                    accept  = 1'b1;
                    state_n = SERVICE;
                end
            end
            SERVICE: begin
                if (retfie) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Vector arithmetic is done at PC width so wrap-around falls out naturally.
    assign vec_addr   = VECTOR_BASE + PC_W'(active_id) * PC_W'(VECTOR_STRIDE);
    assign int_addr   = int_goto ? vec_addr : '0;
    assign int_call   = int_goto;
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

    logic        clk;
    logic        reset;
    logic        pause;
    logic [3:0]  irq;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic        gie_wr;
    logic        gie_data;
    logic        safe;
    logic        retfie;
    logic        int_goto;
    logic        int_call;
    logic [11:0] int_addr;
    logic        in_service;
    logic [1:0]  active_id;
    logic [3:0]  pending;

    int tests = 0;
    int fails = 0;

    irq_ctrl #(
        .NUM_IRQ       (4),
        .VECTOR_BASE   (12'h004),
        .VECTOR_STRIDE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .irq        (irq),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .gie_wr     (gie_wr),
        .gie_data   (gie_data),
        .safe       (safe),
        .retfie     (retfie),
        .int_goto   (int_goto),
        .int_call   (int_call),
        .int_addr   (int_addr),
        .in_service (in_service),
        .active_id  (active_id),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_cfg(input logic g, input logic [3:0] m);
        gie_wr    = 1'b1;
        gie_data  = g;
        mask_wr   = 1'b1;
        mask_data = m;
        tick();
        gie_wr    = 1'b0;
        mask_wr   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL rst_goto: got %b want 0", int_goto); end
        tests++; if (int_call !== 1'b0) begin fails++; $display("FAIL rst_call: got %b want 0", int_call); end
        tests++; if (int_addr !== 12'h000) begin fails++; $display("FAIL rst_addr: got %h want 000", int_addr); end
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL rst_insvc: got %b want 0", in_service); end
        tests++; if (active_id !== 2'd0) begin fails++; $display("FAIL rst_id: got %0d want 0", active_id); end
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL rst_pending: got %b want 0000", pending); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        write_cfg(1'b1, 4'b1111);
        safe   = 1'b1;
        irq[2] = 1'b1;
        tick();
        tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL basic_pend_set: got %b want 0100", pending); end
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL basic_goto_early: got %b want 0", int_goto); end
        tick();
        tests++; if (int_goto !== 1'b1) begin fails++; $display("FAIL basic_goto: got %b want 1", int_goto); end
        tests++; if (int_call !== 1'b1) begin fails++; $display("FAIL basic_call: got %b want 1", int_call); end
        tests++; if (int_addr !== 12'h00C) begin fails++; $display("FAIL basic_addr: got %h want 00C", int_addr); end
        tests++; if (active_id !== 2'd2) begin fails++; $display("FAIL basic_id: got %0d want 2", active_id); end
        tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL basic_goto_pulse: got %b want 0", int_goto); end
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL basic_pend_clr: got %b want 0000", pending); end
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL basic_insvc: got %b want 1", in_service); end
        irq[2] = 1'b0;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL basic_ret: got %b want 0", in_service); end
    endtask

    task automatic test_priority();
        irq = 4'b1010;
        tick();
        tests++; if (pending !== 4'b1010) begin fails++; $display("FAIL prio_pend: got %b want 1010", pending); end
        tick();
        tests++; if (int_goto !== 1'b1) begin fails++; $display("FAIL prio_goto1: got %b want 1", int_goto); end
        tests++; if (int_addr !== 12'h008) begin fails++; $display("FAIL prio_addr1: got %h want 008", int_addr); end
        tick();
        tests++; if (pending !== 4'b1000) begin fails++; $display("FAIL prio_pend_left: got %b want 1000", pending); end
        irq    = 4'b0000;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL prio_idle_gap: got %b want 0", int_goto); end
        tick();
        tests++; if (int_addr !== 12'h010) begin fails++; $display("FAIL prio_addr3: got %h want 010", int_addr); end
        tick();
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL prio_pend_done: got %b want 0000", pending); end
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
    endtask

    task automatic test_gating();
        write_cfg(1'b1, 4'b1110);
        irq[0] = 1'b1;
        tick();
        tests++; if (pending !== 4'b0001) begin fails++; $display("FAIL gate_pend: got %b want 0001", pending); end
        repeat (3) tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL gate_mask_goto: got %b want 0", int_goto); end
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL gate_mask_insvc: got %b want 0", in_service); end
        safe = 1'b0;
        write_cfg(1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL gate_safe_c%0d: got %b want 0", i, int_goto); end
        end
        safe  = 1'b1;
        pause = 1'b1;
        #1;
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL gate_pause0: got %b want 0", int_goto); end
        tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL gate_pause1: got %b want 0", int_goto); end
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL gate_pause_insvc: got %b want 0", in_service); end
        pause = 1'b0;
        #1;
        tests++; if (int_addr !== 12'h004) begin fails++; $display("FAIL gate_fire_addr: got %h want 004", int_addr); end
        tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL gate_once: got %b want 0", int_goto); end
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL gate_insvc: got %b want 1", in_service); end
        irq[0] = 1'b0;
        pause  = 1'b1;
        retfie = 1'b1;
        tick();
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL gate_pause_ret: got %b want 1", in_service); end
        pause = 1'b0;
        tick();
        retfie = 1'b0;
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL gate_ret: got %b want 0", in_service); end
    endtask

    task automatic test_collision();
        irq[2] = 1'b1;
        tick();
        irq[2] = 1'b0;
        tick();
        irq[2] = 1'b1;
        #1;
        tests++; if (int_goto !== 1'b1) begin fails++; $display("FAIL coll_goto: got %b want 1", int_goto); end
        tick();
        tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL coll_pend: got %b want 0100", pending); end
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL coll_insvc: got %b want 1", in_service); end
        irq[2] = 1'b0;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        tick();
        tests++; if (int_addr !== 12'h00C) begin fails++; $display("FAIL coll_refire: got %h want 00C", int_addr); end
        tick();
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL coll_pend_done: got %b want 0000", pending); end
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
    endtask

    task automatic test_commit();
        safe   = 1'b0;
        irq[1] = 1'b1;
        tick();
        tick();
        write_cfg(1'b0, 4'b0000);
        safe = 1'b1;
        #1;
        tests++; if (int_addr !== 12'h008) begin fails++; $display("FAIL commit_addr: got %h want 008", int_addr); end
        tick();
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL commit_insvc: got %b want 1", in_service); end
        irq[1] = 1'b0;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
    endtask

    task automatic test_reset_mid();
        write_cfg(1'b1, 4'b1111);
        irq[0] = 1'b1;
        repeat (3) tick();
        tests++; if (in_service !== 1'b1) begin fails++; $display("FAIL rmid_insvc: got %b want 1", in_service); end
        reset = 1'b1;
        tick();
        tests++; if (in_service !== 1'b0) begin fails++; $display("FAIL rmid_insvc0: got %b want 0", in_service); end
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL rmid_goto: got %b want 0", int_goto); end
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL rmid_pend: got %b want 0000", pending); end
        tests++; if (active_id !== 2'd0) begin fails++; $display("FAIL rmid_id: got %0d want 0", active_id); end
        reset = 1'b0;
        tick();
        irq[1] = 1'b1;
        tick();
        tests++; if (pending !== 4'b0010) begin fails++; $display("FAIL rmid_held: got %b want 0010", pending); end
        tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL rmid_gie0: got %b want 0", int_goto); end
        write_cfg(1'b1, 4'b1111);
        tick();
        tests++; if (active_id !== 2'd1) begin fails++; $display("FAIL rmid_win: got %0d want 1", active_id); end
        tests++; if (int_addr !== 12'h008) begin fails++; $display("FAIL rmid_addr1: got %h want 008", int_addr); end
        tick();
        irq[1] = 1'b0;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        repeat (3) tick();
        tests++; if (int_goto !== 1'b0) begin fails++; $display("FAIL rmid_quiet: got %b want 0", int_goto); end
        tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL rmid_quiet_pend: got %b want 0000", pending); end
        irq[0] = 1'b0;
        tick();
        irq[0] = 1'b1;
        tick();
        tests++; if (pending !== 4'b0001) begin fails++; $display("FAIL rmid_new_edge: got %b want 0001", pending); end
        tick();
        tests++; if (int_addr !== 12'h004) begin fails++; $display("FAIL rmid_addr0: got %h want 004", int_addr); end
        tick();
        irq    = 4'b0000;
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        pause     = 1'b0;
        irq       = 4'b0000;
        mask_wr   = 1'b0;
        mask_data = 4'b0000;
        gie_wr    = 1'b0;
        gie_data  = 1'b0;
        safe      = 1'b0;
        retfie    = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_gating();
        test_collision();
        test_commit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
